// File: rtl/song_reader_ctrl.sv
// song_reader_ctrl
//   Walks one of four stored songs (NOTES_PER_SONG notes each) and hands the
//   notes one at a time to the note player, with an activation handshake
//   towards the chord-activation unit in front of every note.
//
//   Optional feature: define SONG_LOOP_EN to make a finished song restart
//   immediately (same song, same direction) while play stays high.
//
// Ports
//   clk, reset      system clock; synchronous active-high reset
//   play            1 = run/resume, 0 = pause (freezes everything outside IDLE/DONE)
//   song[1:0]       song select, captured when leaving IDLE
//   note_done       note player finished the current note
//   ff_switch0      fast-forward: durations halved (minimum 1)
//   r_switch1       rewind: notes walked in reverse; overrides ff_switch0
//   activate_done   acknowledge for activate
//   song_done       one-cycle pulse at end of song
//   note[5:0]       current note code
//   duration[5:0]   current note duration after fast-forward adjustment
//   new_note        one-cycle pulse when note/duration become valid
//   activate        request to downstream unit, held until activate_done
//
// Handshake: activate rises on entry to ACTIVATE and stays high every cycle
// until a cycle in which activate_done=1 (and play=1) is sampled; that cycle
// is the last one with activate high. new_note follows in the next cycle.
module song_reader_ctrl #(
  parameter int NOTES_PER_SONG = 32,
  parameter int ROM_LATENCY    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       play,
  input  logic [1:0] song,
  input  logic       note_done,
  input  logic       ff_switch0,
  input  logic       r_switch1,
  input  logic       activate_done,
  output logic       song_done,
  output logic [5:0] note,
  output logic [5:0] duration,
  output logic       new_note,
  output logic       activate
);

  localparam int IDX_W  = $clog2(NOTES_PER_SONG);
  localparam int ADDR_W = IDX_W + 2;
  localparam int LAT_W  = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NOTES_PER_SONG - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ROM_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_ACTIVATE,
    S_NEW_NOTE,
    S_WAIT,
    S_ADVANCE,
    S_DONE
  } state_t;

  state_t state, state_d;

  logic [1:0]       song_q;
  logic [IDX_W-1:0] idx;
  logic [LAT_W-1:0] lat_cnt;

  // ---------------------------------------------------------------------------
  // Song ROM: address {song_q, idx}, data {note[11:6], dur[5:0]}.
  // Contents are a fixed arithmetic pattern; one entry in song 3 (index 20)
  // carries duration 0, the end-of-song marker, so song 3 ends early.
  // ---------------------------------------------------------------------------
  function automatic logic [11:0] rom_lookup(input logic [ADDR_W-1:0] a);
    int unsigned ai;
    logic [5:0]  n;
    logic [5:0]  d;
    ai = {{(32-ADDR_W){1'b0}}, a};
    n  = 6'(ai * 5 + 3);
    if (ai == 3 * NOTES_PER_SONG + 20) d = 6'd0;
    else                               d = 6'((ai % 13) + 1);
    return {n, d};
  endfunction

  logic [ADDR_W-1:0] rom_addr;
  logic [11:0]       rom_pipe [ROM_LATENCY];
  logic [5:0]        rom_note;
  logic [5:0]        rom_dur;
  logic [5:0]        half_dur;

  assign rom_addr = {song_q, idx};
  assign rom_note = rom_pipe[ROM_LATENCY-1][11:6];
  assign rom_dur  = rom_pipe[ROM_LATENCY-1][5:0];
  assign half_dur = (rom_dur[5:1] == 5'd0) ? 6'd1 : {1'b0, rom_dur[5:1]};

  // Registered read with ROM_LATENCY stages; the address is held constant
  // throughout FETCH so the pipe output is valid when LATCH is reached.
  always_ff @(posedge clk) begin
    rom_pipe[0] <= rom_lookup(rom_addr);
    for (int i = 1; i < ROM_LATENCY; i++) rom_pipe[i] <= rom_pipe[i-1];
  end

  // End of walk in the currently requested direction.
  logic at_end;
  assign at_end = r_switch1 ? (idx == '0) : (idx == IDX_LAST);

  // ---------------------------------------------------------------------------
  // Next-state logic. Every transition outside IDLE/DONE requires play=1,
  // which is what implements pause.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:     if (play) state_d = S_FETCH;
      S_FETCH:    if (play && lat_cnt == LAT_LAST) state_d = S_LATCH;
      S_LATCH:    if (play) state_d = (rom_dur == 6'd0) ? S_DONE : S_ACTIVATE;
      S_ACTIVATE: if (play && activate_done) state_d = S_NEW_NOTE;
      S_NEW_NOTE: if (play) state_d = S_WAIT;
      S_WAIT:     if (play && note_done) state_d = S_ADVANCE;
      S_ADVANCE:  if (play) state_d = at_end ? S_DONE : S_FETCH;
`ifdef SONG_LOOP_EN
      S_DONE:     state_d = play ? S_FETCH : S_IDLE;
`else
      S_DONE:     state_d = S_IDLE;
`endif
      default:    state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, datapath and registered outputs.
  // Pulses are generated on state entry only, so a pause while sitting in
  // NEW_NOTE does not repeat new_note; activate tracks the ACTIVATE state and
  // therefore stays high through a pause.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      song_q    <= 2'd0;
      lat_cnt   <= '0;
      note      <= 6'd0;
      duration  <= 6'd0;
      song_done <= 1'b0;
      new_note  <= 1'b0;
      activate  <= 1'b0;
    end else begin
      state     <= state_d;
      new_note  <= (state_d == S_NEW_NOTE) && (state != S_NEW_NOTE);
      song_done <= (state_d == S_DONE) && (state != S_DONE);
      activate  <= (state_d == S_ACTIVATE);

      if (state == S_FETCH && state_d == S_FETCH) begin
        if (play) lat_cnt <= lat_cnt + 1'b1;
      end else begin
        lat_cnt <= '0;
      end

      case (state)
        S_IDLE: begin
          if (play) begin
            song_q <= song;
            idx    <= r_switch1 ? IDX_LAST : '0;
          end
        end
        S_LATCH: begin
          if (play && rom_dur != 6'd0) begin
            note     <= rom_note;
            duration <= (ff_switch0 && !r_switch1) ? half_dur : rom_dur;
          end
        end
        S_ADVANCE: begin
          if (play && !at_end) idx <= r_switch1 ? idx - 1'b1 : idx + 1'b1;
        end
        S_DONE: begin
`ifdef SONG_LOOP_EN
          if (play) idx <= r_switch1 ? IDX_LAST : '0;
          else      idx <= '0;
`else
          idx <= '0;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_song_reader_ctrl.sv
// tb_song_reader_ctrl
//   Bench for song_reader_ctrl. The reference model produces, for a chosen
//   song/direction/fast-forward setting, the full list of (note, duration)
//   pairs the player must receive followed by one song_done; a monitor pops
//   that list whenever the DUT pulses new_note or song_done.
module tb_song_reader_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       play = 1'b0;
  logic [1:0] song = 2'd0;
  logic       note_done = 1'b0;
  logic       ff_switch0 = 1'b0;
  logic       r_switch1 = 1'b0;
  logic       activate_done = 1'b0;
  logic       song_done;
  logic [5:0] note;
  logic [5:0] duration;
  logic       new_note;
  logic       activate;

  song_reader_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .play          (play),
    .song          (song),
    .note_done     (note_done),
    .ff_switch0    (ff_switch0),
    .r_switch1     (r_switch1),
    .activate_done (activate_done),
    .song_done     (song_done),
    .note          (note),
    .duration      (duration),
    .new_note      (new_note),
    .activate      (activate)
  );

  // ---------------- clock / reset sampling ----------------
  always #5 clk = ~clk;

  logic play_s, rst_s;
  always @(posedge clk) begin
    play_s <= play;
    rst_s  <= reset;
  end

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int nn_cnt = 0;
  int act_cnt = 0;
  logic [12:0] exp_q[$];   // {is_done, note, duration}
  logic [5:0]  note_p, dur_p;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int m_note(input int a);
    return (a * 5 + 3) % 64;
  endfunction

  function automatic int m_dur(input int a);
    if (a == 116) return 0;
    return (a % 13) + 1;
  endfunction

  task automatic push_song(input int s, input bit ff, input bit rw);
    int i;
    int a;
    int d;
    int ed;
    i = rw ? 31 : 0;
    while (1) begin
      a = s * 32 + i;
      d = m_dur(a);
      if (d == 0) break;
      if (ff && !rw) ed = (d / 2 < 1) ? 1 : d / 2;
      else           ed = d;
      exp_q.push_back({1'b0, 6'(m_note(a)), 6'(ed)});
      if (rw ? (i == 0) : (i == 31)) break;
      i = rw ? i - 1 : i + 1;
    end
    exp_q.push_back({1'b1, 12'h000});
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [12:0] e;
    if (!reset && rst_s === 1'b0) begin
      if (activate) act_cnt++;
      if (new_note && song_done) check("pulse_overlap", 1, 0);
      if (new_note || song_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {30'd0, new_note, song_done}, 0);
        end else begin
          e = exp_q.pop_front();
          if (new_note) check("note_dur", {19'd0, 1'b0, note, duration}, {19'd0, e});
          else          check("song_done_order", {19'd0, 1'b1, 12'h000}, {19'd0, e});
        end
        if (song_done) done_cnt++;
        if (new_note) nn_cnt++;
      end
      if (play_s === 1'b0) begin
        check("pause_pulse", {30'd0, new_note, song_done}, 0);
        check("pause_hold", {20'd0, note, duration}, {20'd0, note_p, dur_p});
      end
    end
    note_p = note;
    dur_p  = duration;
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int cycles);
    @(negedge clk); #1;
    reset = 1'b1;
    play  = 1'b0;
    repeat (cycles) @(negedge clk);
    check("rst_note", note, 0);
    check("rst_duration", duration, 0);
    check("rst_new_note", new_note, 0);
    check("rst_song_done", song_done, 0);
    check("rst_activate", activate, 0);
    exp_q.delete();
    #1 reset = 1'b0;
  endtask

  task automatic start_song(input int s, input bit ff, input bit rw);
    @(negedge clk); #1;
    song       = 2'(s);
    ff_switch0 = ff;
    r_switch1  = rw;
    push_song(s, ff, rw);
    play = 1'b1;
  endtask

  // Runs until done_cnt/nn_cnt reach their targets; optional random timing.
  task automatic run_until(input int done_target, input int nn_target,
                           input int max_cyc, input bit rnd);
    int n;
    n = 0;
    while (done_cnt < done_target && nn_cnt < nn_target && n < max_cyc) begin
      @(negedge clk); #1;
      n++;
      if (rnd) begin
        play          = ($urandom_range(0, 9) != 0);
        note_done     = ($urandom_range(0, 3) != 0);
        activate_done = ($urandom_range(0, 2) != 0);
      end
    end
    if (done_cnt < done_target && nn_cnt < nn_target)
      check("run_timeout", done_cnt, done_target);
    play = 1'b0;
  endtask

  task automatic settle();
    play = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int act_lat;
    int a0;
    int d0;
    bit ff_r;
    bit rw_r;

    do_reset(2);

    // Song 0 forward with handshakes tied high: start latency, one activate
    // cycle per note, full song.
    @(negedge clk); #1;
    note_done     = 1'b1;
    activate_done = 1'b1;
    song          = 2'd0;
    push_song(0, 0, 0);
    a0   = act_cnt;
    d0   = done_cnt;
    play = 1'b1;
    lat = 0;
    act_lat = 0;
    while (!new_note && lat < 20) begin
      @(negedge clk); #1;
      lat++;
      if (activate && act_lat == 0) act_lat = lat;
    end
    check("start_latency", lat, 4);
    check("activate_latency", act_lat, 3);
    run_until(d0 + 1, 1 << 30, 2000, 0);
    check("activate_one_cycle_each", act_cnt - a0, 32);
    settle();

    // Withheld acknowledge on song 1.
    activate_done = 1'b0;
    note_done     = 1'b1;
    start_song(1, 0, 0);
    lat = 0;
    while (!activate && lat < 20) begin
      @(negedge clk); #1;
      lat++;
    end
    check("stall_activate_seen", activate, 1);
    repeat (5) begin
      @(negedge clk); #1;
      check("stall_activate_held", activate, 1);
      check("stall_no_new_note", new_note, 0);
    end
    activate_done = 1'b1;
    @(negedge clk); #1;
    check("ack_new_note", new_note, 1);
    check("ack_activate_low", activate, 0);
    run_until(done_cnt + 1, 1 << 30, 3000, 1);
    settle();

    // Reset in the middle of a song.
    start_song(2, 1, 0);
    run_until(1 << 30, nn_cnt + 3, 500, 1);
    do_reset(1);
    settle();

    // Directed corner songs: early end marker, rewind, fast-forward.
    start_song(3, 0, 0);
    run_until(done_cnt + 1, 1 << 30, 3000, 1);
    settle();
    start_song(3, 0, 1);
    run_until(done_cnt + 1, 1 << 30, 3000, 1);
    settle();
    start_song(0, 1, 0);
    run_until(done_cnt + 1, 1 << 30, 3000, 1);
    settle();
    start_song(2, 1, 1);
    run_until(done_cnt + 1, 1 << 30, 3000, 1);
    settle();

    // Randomized songs and settings.
    for (int k = 0; k < 8; k++) begin
      ff_r = 1'($urandom_range(0, 1));
      rw_r = 1'($urandom_range(0, 1));
      start_song(int'($urandom_range(0, 3)), ff_r, rw_r);
      run_until(done_cnt + 1, 1 << 30, 3000, 1);
      settle();
    end

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
